// File: rtl/ex_logic_stage.sv
// Execute-stage logic unit for the MIPS pipeline: a bitwise ALU built from AND/OR/NOT
// followed by a two-entry (head + skid) EX/MEM buffer that doubles as a forwarding source.
module ex_logic_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [15:0]      in_imm,
  input  logic             in_use_imm,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_regwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [REGW-1:0]  out_rd,
  output logic             out_regwrite,
  output logic             out_illegal,
  output logic             fwd_valid,
  output logic [REGW-1:0]  fwd_rd,
  output logic [WIDTH-1:0] fwd_data,
  output logic [31:0]      op_count
);

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpNor  = 3'b010,
    OpXor  = 3'b011,
    OpNotA = 3'b100,
    OpLui  = 3'b101,
    OpPass = 3'b110,
    OpRsvd = 3'b111
  } logicOpE;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [REGW-1:0]  rd;
    logic             regwrite;
    logic             illegal;
  } entryT;

  logic [WIDTH-1:0] bEff;
  logic [WIDTH-1:0] andAB, orAB, notA, notB, xorAB;
  entryT            newEntry;

  entryT            head_q, head_d, skid_q, skid_d;
  logic             headValid_q, headValid_d, skidValid_q, skidValid_d;
  logic [31:0]      opCount_q;
  logic [31:0]      opCount_d;

  logic             accept;
  logic             drain;

  assign bEff  = in_use_imm ? {{(WIDTH-16){1'b0}}, in_imm} : in_b;
  assign andAB = in_a & bEff;
  assign orAB  = in_a | bEff;
  assign notA  = ~in_a;
  assign notB  = ~bEff;
  // XOR is composed from the AND/OR/NOT primitives rather than a native XOR gate.
  assign xorAB = (in_a & notB) | (notA & bEff);

  always_comb begin
    newEntry.result  = '0;
    newEntry.illegal = 1'b0;
    unique case (logicOpE'(in_op))
      OpAnd:   newEntry.result = andAB;
      OpOr:    newEntry.result = orAB;
      OpNor:   newEntry.result = ~orAB;
      OpXor:   newEntry.result = xorAB;
      OpNotA:  newEntry.result = notA;
      OpLui:   newEntry.result = {in_imm, {(WIDTH-16){1'b0}}};
      OpPass:  newEntry.result = in_a;
      OpRsvd:  newEntry.illegal = 1'b1;
      default: newEntry.illegal = 1'b1;
    endcase
    newEntry.rd       = in_rd;
    newEntry.regwrite = in_regwrite & (in_rd != '0) & ~newEntry.illegal;
  end

  assign in_ready = ~reset & ~skidValid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = headValid_q & out_ready;

  // Skid always refills head first; accept with skid valid cannot happen since in_ready is low.
  always_comb begin
    head_d      = head_q;
    headValid_d = headValid_q;
    skid_d      = skid_q;
    skidValid_d = skidValid_q;
    if (flush) begin
      head_d      = '0;
      headValid_d = 1'b0;
      skid_d      = '0;
      skidValid_d = 1'b0;
    end else if (drain) begin
      if (skidValid_q) begin
        head_d      = skid_q;
        headValid_d = 1'b1;
        skidValid_d = 1'b0;
      end else if (accept) begin
        head_d      = newEntry;
        headValid_d = 1'b1;
      end else begin
        headValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!headValid_q) begin
        head_d      = newEntry;
        headValid_d = 1'b1;
      end else begin
        skid_d      = newEntry;
        skidValid_d = 1'b1;
      end
    end
  end

  assign opCount_d = opCount_q + {31'b0, drain};

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      headValid_q <= 1'b0;
      skid_q      <= '0;
      skidValid_q <= 1'b0;
      opCount_q   <= '0;
    end else begin
      head_q      <= head_d;
      headValid_q <= headValid_d;
      skid_q      <= skid_d;
      skidValid_q <= skidValid_d;
      opCount_q   <= opCount_d;
    end
  end

  assign out_valid    = headValid_q;
  assign out_result   = head_q.result;
  assign out_rd       = head_q.rd;
  assign out_regwrite = head_q.regwrite;
  assign out_illegal  = head_q.illegal;
  assign fwd_valid    = headValid_q & head_q.regwrite;
  assign fwd_rd       = head_q.rd;
  assign fwd_data     = head_q.result;
  assign op_count     = opCount_q;

endmodule
